// File: rtl/pll_reset_ctrl_if.sv
// PLL-side and status signals of the reset/lock supervisor.
// The master drives pll_locked and clr_stats; the supervisor is the slave.
interface pll_reset_ctrl_if;
  logic       pll_locked;
  logic       clr_stats;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic [7:0] relock_cnt;
  logic [7:0] timeout_cnt;

  modport master (
    output pll_locked, clr_stats,
    input  pll_rst, sys_rst, ready, relock_cnt, timeout_cnt
  );

  modport slave (
    input  pll_locked, clr_stats,
    output pll_rst, sys_rst, ready, relock_cnt, timeout_cnt
  );
endinterface

// File: rtl/pll_reset_ctrl.sv
// PLL reset and lock supervisor: pulses the PLL reset, qualifies lock for a
// programmable time before releasing sys_rst, and counts relock/timeout events.
module pll_reset_ctrl #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int CNT_W               = 17
) (
  input  logic            refclk,
  input  logic            rst,
  pll_reset_ctrl_if.slave bus
);

  typedef enum logic [1:0] {RESET_PLL, WAIT_LOCK, STABLE, RUN} state_t;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             locked_p0, locked_s;
  logic             pll_rst_q, pll_rst_n;
  logic             sys_rst_q, sys_rst_n;
  logic             ready_q, ready_n;
  logic             relock_inc, timeout_inc;
  logic [7:0]       relock_q, timeout_q;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Stage p0 -> locked_s: two-flop synchronizer for the asynchronous lock flag
  always_ff @(posedge refclk) begin
    if (rst) begin
      locked_p0 <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      locked_p0 <= bus.pll_locked;
      locked_s  <= locked_p0;
    end
  end

  // Supervisor state; outputs are registered alongside it
  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= RESET_PLL;
      cnt       <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pll_rst_q <= pll_rst_n;
      sys_rst_q <= sys_rst_n;
      ready_q   <= ready_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    pll_rst_n   = pll_rst_q;
    sys_rst_n   = sys_rst_q;
    ready_n     = ready_q;
    relock_inc  = 1'b0;
    timeout_inc = 1'b0;
    case (state)
      RESET_PLL: begin
        pll_rst_n = 1'b1;
        sys_rst_n = 1'b1;
        ready_n   = 1'b0;
        if (cnt == RST_LAST) begin
          state_n   = WAIT_LOCK;
          cnt_n     = '0;
          pll_rst_n = 1'b0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_n = STABLE;
          cnt_n   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          state_n     = RESET_PLL;
          cnt_n       = '0;
          pll_rst_n   = 1'b1;
          timeout_inc = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STABLE: begin
        // Any dropout restarts qualification with a fresh timeout window
        if (!locked_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_n   = RUN;
          cnt_n     = '0;
          sys_rst_n = 1'b0;
          ready_n   = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      RUN: begin
        cnt_n = '0;
        if (!locked_s) begin
          state_n    = RESET_PLL;
          pll_rst_n  = 1'b1;
          sys_rst_n  = 1'b1;
          ready_n    = 1'b0;
          relock_inc = 1'b1;
        end
      end
      default: begin
        state_n = RESET_PLL;
        cnt_n   = '0;
      end
    endcase
  end

  // Diagnostic counters: clear has priority over a coincident increment
  always_ff @(posedge refclk) begin
    if (rst) begin
      relock_q  <= '0;
      timeout_q <= '0;
    end else if (bus.clr_stats) begin
      relock_q  <= '0;
      timeout_q <= '0;
    end else begin
      if (relock_inc)  relock_q  <= sat_inc(relock_q);
      if (timeout_inc) timeout_q <= sat_inc(timeout_q);
    end
  end

  assign bus.pll_rst     = pll_rst_q;
  assign bus.sys_rst     = sys_rst_q;
  assign bus.ready       = ready_q;
  assign bus.relock_cnt  = relock_q;
  assign bus.timeout_cnt = timeout_q;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Scoreboard bench for pll_reset_ctrl: a timestamp-based reference model queues
// the expected outputs of every edge and a monitor compares them on the falling edge.
module tb_pll_reset_ctrl;
  localparam int P = 4;
  localparam int L = 8;
  localparam int T = 32;

  logic refclk = 1'b0;
  logic rst;

  pll_reset_ctrl_if bus();

  pll_reset_ctrl #(
    .PLL_RST_CYCLES(P), .LOCK_STABLE_CYCLES(L), .LOCK_TIMEOUT_CYCLES(T), .CNT_W(6)
  ) dut (
    .refclk(refclk),
    .rst   (rst),
    .bus   (bus.slave)
  );

  always #5 refclk = ~refclk;

  int n_pass  = 0;
  int n_total = 0;
  logic [18:0] exp_q[$];

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
  endtask

  // Reference model: phases tracked by the edge index at which each began
  typedef enum {PH_PLLRST, PH_WAIT, PH_QUAL, PH_RUN} phase_t;
  phase_t ph = PH_PLLRST;
  int     t_now = 0, t_start = 0;
  bit     m_s1 = 0, m_s2 = 0;
  bit     e_pll = 1, e_sys = 1, e_rdy = 0;
  int     e_relock = 0, e_to = 0;

  initial forever begin : model
    bit ls, relock_ev, to_ev;
    @(posedge refclk);
    t_now++;
    relock_ev = 0;
    to_ev     = 0;
    if (rst) begin
      ph = PH_PLLRST; t_start = t_now; m_s1 = 0; m_s2 = 0;
      e_pll = 1; e_sys = 1; e_rdy = 0; e_relock = 0; e_to = 0;
    end else begin
      ls   = m_s2;
      m_s2 = m_s1;
      m_s1 = bus.pll_locked;
      case (ph)
        PH_PLLRST: if (t_now - t_start == P) begin
          ph = PH_WAIT; t_start = t_now; e_pll = 0;
        end
        PH_WAIT: if (ls) begin
          ph = PH_QUAL; t_start = t_now;
        end else if (t_now - t_start == T) begin
          ph = PH_PLLRST; t_start = t_now; e_pll = 1; to_ev = 1;
        end
        PH_QUAL: if (!ls) begin
          ph = PH_WAIT; t_start = t_now;
        end else if (t_now - t_start == L) begin
          ph = PH_RUN; e_sys = 0; e_rdy = 1;
        end
        PH_RUN: if (!ls) begin
          ph = PH_PLLRST; t_start = t_now; e_pll = 1; e_sys = 1; e_rdy = 0; relock_ev = 1;
        end
        default: ph = PH_PLLRST;
      endcase
      if (bus.clr_stats) begin
        e_relock = 0; e_to = 0;
      end else begin
        if (relock_ev && e_relock < 255) e_relock++;
        if (to_ev && e_to < 255) e_to++;
      end
    end
    exp_q.push_back({e_pll, e_sys, e_rdy, 8'(e_relock), 8'(e_to)});
  end

  initial forever begin : monitor
    logic [18:0] e, a;
    @(negedge refclk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.pll_rst, bus.sys_rst, bus.ready, bus.relock_cnt, bus.timeout_cnt};
      n_total++;
      if (a == e) n_pass++;
      else $display("FAIL outputs t=%0t: got pll_rst/sys_rst/ready/relock/timeout=%0b/%0b/%0b/%0d/%0d, required %0b/%0b/%0b/%0d/%0d",
                    $time, a[18], a[17], a[16], a[15:8], a[7:0], e[18], e[17], e[16], e[15:8], e[7:0]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic do_reset();
    @(negedge refclk);
    rst = 1'b1;
    @(negedge refclk);
    rst = 1'b0;
  endtask

  task automatic wait_ready(input logic lvl, input int max, input string name);
    int n;
    n = 0;
    while (bus.ready !== lvl && n < max) begin
      @(negedge refclk);
      n++;
    end
    check(name, int'(bus.ready), int'(lvl));
  endtask

  task automatic count_pll_rst_high(input string name);
    int n;
    n = 0;
    while (bus.pll_rst && n < 50) begin
      n++;
      @(negedge refclk);
    end
    check(name, n, P);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int n;
    rst            = 1'b1;
    bus.pll_locked = 1'b0;
    bus.clr_stats  = 1'b0;
    cyc(2);

    // Reset release, lock rises 10 cycles later
    do_reset();
    check("reset_sys_rst", int'(bus.sys_rst), 1);
    check("reset_ready", int'(bus.ready), 0);
    count_pll_rst_high("pll_rst_width_after_reset");
    cyc(6);
    bus.pll_locked = 1'b1;
    n = 0;
    do begin @(negedge refclk); n++; end while (bus.sys_rst && n < 100);
    check("lock_to_sys_rst_edges", n, 3 + L);
    check("ready_with_sys_rst", int'(bus.ready), 1);
    check("relock_after_first_lock", int'(bus.relock_cnt), 0);
    check("timeout_after_first_lock", int'(bus.timeout_cnt), 0);

    // Lock never arrives: three timeout periods
    bus.pll_locked = 1'b0;
    do_reset();
    cyc(3 * (P + T) + 2);
    check("timeout_cnt_three", int'(bus.timeout_cnt), 3);
    check("sys_rst_held_no_lock", int'(bus.sys_rst), 1);

    // Dropout during qualification
    n = 0;
    while (bus.pll_rst && n < 100) begin @(negedge refclk); n++; end
    check("pll_rst_release_wait", int'(bus.pll_rst), 0);
    bus.pll_locked = 1'b1;
    cyc(5);
    bus.pll_locked = 1'b0;
    cyc(3);
    check("sys_rst_held_after_dropout", int'(bus.sys_rst), 1);
    bus.pll_locked = 1'b1;
    n = 0;
    do begin @(negedge refclk); n++; end while (bus.sys_rst && n < 100);
    check("relock_to_sys_rst_edges", n, 3 + L);

    // Loss of lock in RUN
    bus.pll_locked = 1'b0;
    n = 0;
    do begin @(negedge refclk); n++; end while (bus.ready && n < 50);
    check("loss_to_ready_low_edges", n, 3);
    check("loss_sys_rst", int'(bus.sys_rst), 1);
    check("loss_relock_cnt", int'(bus.relock_cnt), 1);
    count_pll_rst_high("pll_rst_width_after_loss");
    bus.pll_locked = 1'b1;

    // Many forced losses saturate relock_cnt
    for (int i = 0; i < 300; i++) begin
      wait_ready(1'b1, 200, "ready_before_loss");
      bus.pll_locked = 1'b0;
      cyc($urandom_range(1, 4));
      bus.pll_locked = 1'b1;
      wait_ready(1'b0, 50, "ready_after_loss");
    end
    check("relock_saturated", int'(bus.relock_cnt), 255);

    // Clear on the same edge as an increment
    wait_ready(1'b1, 200, "ready_before_clr");
    bus.pll_locked = 1'b0;
    cyc(2);
    bus.clr_stats = 1'b1;
    cyc(1);
    bus.clr_stats = 1'b0;
    check("clr_beats_increment", int'(bus.relock_cnt), 0);
    bus.pll_locked = 1'b1;

    // Synchronous reset while running
    wait_ready(1'b1, 200, "ready_before_rst");
    do_reset();
    check("rst_run_pll_rst", int'(bus.pll_rst), 1);
    check("rst_run_sys_rst", int'(bus.sys_rst), 1);
    check("rst_run_ready", int'(bus.ready), 0);
    check("rst_run_timeout", int'(bus.timeout_cnt), 0);
    wait_ready(1'b1, 100, "ready_after_rst_run");

    // Randomized lock activity with occasional clears and resets
    repeat (60) begin
      bus.pll_locked = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(1, 50)) begin
        @(negedge refclk);
        bus.clr_stats = ($urandom_range(0, 31) == 0);
        rst           = ($urandom_range(0, 149) == 0);
      end
    end
    bus.clr_stats = 1'b0;
    rst           = 1'b0;
    cyc(4);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
